// File: rtl/lsq_free_list_mp_if.sv
// Dispatch/commit-side bundle for the multi-port LSQ free list.
// master = dispatch/commit driver, slave = the free list itself.
interface lsq_free_list_mp_if #(
    parameter int IDX_W       = 4,
    parameter int DEPTH       = 8,
    parameter int ALLOC_PORTS = 2,
    parameter int REL_PORTS   = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                         flush;
    logic [ALLOC_PORTS-1:0]       alloc_req;
    logic [ALLOC_PORTS-1:0]       alloc_grant;
    logic [ALLOC_PORTS*IDX_W-1:0] alloc_idx;
    logic [REL_PORTS-1:0]         rel_vld;
    logic [REL_PORTS*IDX_W-1:0]   rel_idx;
    logic [CNT_W-1:0]             free_count;
    logic                         empty;
    logic                         full;
    logic                         ovf_err;
    logic                         prot_err;

    modport master (
        output flush, alloc_req, rel_vld, rel_idx,
        input  alloc_grant, alloc_idx, free_count, empty, full, ovf_err, prot_err
    );

    modport slave (
        input  flush, alloc_req, rel_vld, rel_idx,
        output alloc_grant, alloc_idx, free_count, empty, full, ovf_err, prot_err
    );
endinterface

// File: rtl/lsq_free_list_mp.sv
// Multi-port circular free list of LSQ entry indices with explicit occupancy count.
// Grants/indices are combinational from registered state; releases beyond free space are dropped (sticky ovf_err).
module lsq_free_list_mp #(
    parameter int IDX_W       = 4,
    parameter int DEPTH       = 8,
    parameter int ALLOC_PORTS = 2,
    parameter int REL_PORTS   = 2,
    parameter int INIT_BASE   = 0,
    parameter int INIT_STRIDE = 1
) (
    input  logic                clk,
    input  logic                rst,
    lsq_free_list_mp_if.slave   fl
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             prot_q, prot_d;

    logic [ALLOC_PORTS-1:0]       grant;
    logic [ALLOC_PORTS*IDX_W-1:0] peek;
    logic                         non_thermo;
    int                           g;
    int                           r;
    int                           space;

    function automatic logic [IDX_W-1:0] init_val(input int i);
        int v;
        v = INIT_BASE + i * INIT_STRIDE;
        return v[IDX_W-1:0];
    endfunction

    always_comb begin
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        prot_d     = prot_q;
        grant      = '0;
        peek       = '0;
        non_thermo = 1'b0;
        g          = 0;
        r          = 0;
        space      = 0;

        // Grants look only at the registered count; same-cycle releases never help.
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            peek[k*IDX_W +: IDX_W] = mem_q[head_q + PTR_W'(k)];
            if (!fl.flush && fl.alloc_req[k] && (CNT_W'(k) < count_q)) begin
                grant[k] = 1'b1;
                g        = g + 1;
            end
        end

        for (int k = 1; k < ALLOC_PORTS; k++) begin
            if (fl.alloc_req[k] && !fl.alloc_req[k-1]) begin
                non_thermo = 1'b1;
            end
        end

        if (fl.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = init_val(i);
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_W'(DEPTH);
        end else begin
            // Slots freed by this cycle's grants are reusable by this cycle's releases.
            space = DEPTH - int'(count_q) + g;
            for (int l = 0; l < REL_PORTS; l++) begin
                if (fl.rel_vld[l]) begin
                    if (r < space) begin
                        mem_d[tail_q + PTR_W'(r)] = fl.rel_idx[l*IDX_W +: IDX_W];
                        r = r + 1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            head_d  = head_q + PTR_W'(g);
            tail_d  = tail_q + PTR_W'(r);
            count_d = count_q - CNT_W'(g) + CNT_W'(r);
            if (non_thermo) begin
                prot_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= init_val(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
            ovf_q   <= 1'b0;
            prot_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            prot_q  <= prot_d;
        end
    end

    assign fl.alloc_grant = grant;
    assign fl.alloc_idx   = peek;
    assign fl.free_count  = count_q;
    assign fl.empty       = (count_q == '0);
    assign fl.full        = (count_q == CNT_W'(DEPTH));
    assign fl.ovf_err     = ovf_q;
    assign fl.prot_err    = prot_q;
endmodule

// File: tb/tb_lsq_free_list_mp.sv
// Bench for lsq_free_list_mp: directed plan plus random traffic against a queue-based reference.
// A second instance with stride 4 checks the parametrised initial pattern.
module tb_lsq_free_list_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsq_free_list_mp_if #(.IDX_W(4), .DEPTH(8), .ALLOC_PORTS(2), .REL_PORTS(2)) f1 ();
    lsq_free_list_mp_if #(.IDX_W(4), .DEPTH(8), .ALLOC_PORTS(2), .REL_PORTS(2)) f2 ();

    lsq_free_list_mp #(.IDX_W(4), .DEPTH(8), .ALLOC_PORTS(2), .REL_PORTS(2),
                       .INIT_BASE(0), .INIT_STRIDE(1)) u_dut (.clk(clk), .rst(rst), .fl(f1));
    lsq_free_list_mp #(.IDX_W(4), .DEPTH(8), .ALLOC_PORTS(2), .REL_PORTS(2),
                       .INIT_BASE(0), .INIT_STRIDE(4)) u_dut4 (.clk(clk), .rst(rst), .fl(f2));

    int n_chk  = 0;
    int n_pass = 0;

    int q[$];
    bit m_ovf;
    bit m_prot;

    logic [1:0] req2;
    int cap0, cap1, capg;
    int cap2_0, cap2_1, cap2g;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(i);
    endtask

    // Called at posedge+1; checks at negedge, applies the reference update at the next posedge.
    task automatic cycle(input logic [1:0] req, input logic [1:0] vld,
                         input int i0, input int i1, input bit fls);
        int cnt;
        logic [1:0] eg;
        f1.alloc_req = req;
        f1.rel_vld   = vld;
        f1.rel_idx   = {i1[3:0], i0[3:0]};
        f1.flush     = fls;
        f2.alloc_req = req2;
        f2.rel_vld   = 2'b00;
        f2.rel_idx   = '0;
        f2.flush     = fls;
        #4;
        cnt = q.size();
        eg  = 2'b00;
        for (int k = 0; k < 2; k++)
            if (!fls && req[k] && k < cnt) eg[k] = 1'b1;
        chk("grant", int'(f1.alloc_grant), int'(eg));
        for (int k = 0; k < 2; k++)
            if (eg[k]) chk("idx", int'(f1.alloc_idx[k*4 +: 4]), q[k]);
        chk("count", int'(f1.free_count), cnt);
        chk("empty", int'(f1.empty), int'(cnt == 0));
        chk("full", int'(f1.full), int'(cnt == 8));
        chk("ovf", int'(f1.ovf_err), int'(m_ovf));
        chk("prot", int'(f1.prot_err), int'(m_prot));
        cap0   = int'(f1.alloc_idx[3:0]);
        cap1   = int'(f1.alloc_idx[7:4]);
        capg   = int'(f1.alloc_grant);
        cap2_0 = int'(f2.alloc_idx[3:0]);
        cap2_1 = int'(f2.alloc_idx[7:4]);
        cap2g  = int'(f2.alloc_grant);
        @(posedge clk);
        if (fls) begin
            model_reset();
        end else begin
            for (int k = 0; k < int'(eg[0]) + int'(eg[1]); k++) void'(q.pop_front());
            if (vld[0]) begin
                if (q.size() < 8) q.push_back(i0); else m_ovf = 1'b1;
            end
            if (vld[1]) begin
                if (q.size() < 8) q.push_back(i1); else m_ovf = 1'b1;
            end
            if (req == 2'b10) m_prot = 1'b1;
        end
        #1;
    endtask

    initial begin
        int exp2 [8];
        logic [1:0] rq;
        exp2 = '{0, 4, 8, 12, 0, 4, 8, 12};
        rst = 1'b1;
        f1.flush = 1'b0; f1.alloc_req = '0; f1.rel_vld = '0; f1.rel_idx = '0;
        f2.flush = 1'b0; f2.alloc_req = '0; f2.rel_vld = '0; f2.rel_idx = '0;
        req2 = 2'b00;
        m_ovf = 1'b0; m_prot = 1'b0;
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_count", int'(f1.free_count), 8);
        chk("rst_full", int'(f1.full), 1);
        chk("rst_empty", int'(f1.empty), 0);
        chk("rst_grant", int'(f1.alloc_grant), 0);

        // Drain both instances two per cycle.
        req2 = 2'b11;
        for (int c = 0; c < 4; c++) begin
            cycle(2'b11, 2'b00, 0, 0, 1'b0);
            chk("drain_lo", cap0, 2*c);
            chk("drain_hi", cap1, 2*c + 1);
            chk("stride_lo", cap2_0, exp2[2*c]);
            chk("stride_hi", cap2_1, exp2[2*c + 1]);
        end
        req2 = 2'b00;
        cycle(2'b11, 2'b00, 0, 0, 1'b0);
        chk("empty_grant", capg, 0);

        // Releases from empty, then reallocate in release order.
        cycle(2'b00, 2'b11, 3, 5, 1'b0);
        cycle(2'b00, 2'b01, 6, 0, 1'b0);
        chk("rel_count", int'(f1.free_count), 3);
        cycle(2'b11, 2'b00, 0, 0, 1'b0);
        chk("realloc_lo", cap0, 3);
        chk("realloc_hi", cap1, 5);
        cycle(2'b01, 2'b00, 0, 0, 1'b0);
        chk("realloc_one", cap0, 6);

        // Count=1 with concurrent alloc and release.
        cycle(2'b00, 2'b01, 7, 0, 1'b0);
        cycle(2'b11, 2'b11, 9, 10, 1'b0);
        chk("c1_grant", capg, 1);
        chk("c1_idx", cap0, 7);
        chk("c1_count", int'(f1.free_count), 2);
        cycle(2'b11, 2'b00, 0, 0, 1'b0);
        chk("c1_next_lo", cap0, 9);
        chk("c1_next_hi", cap1, 10);

        // Fill, then overflow a release.
        for (int c = 0; c < 4; c++) cycle(2'b00, 2'b11, 2*c, 2*c + 1, 1'b0);
        cycle(2'b00, 2'b01, 4, 0, 1'b0);
        chk("ovf_set", int'(f1.ovf_err), 1);
        chk("ovf_count", int'(f1.free_count), 8);

        // Non-thermometer request at count 1 and count 2.
        for (int c = 0; c < 3; c++) cycle(2'b11, 2'b00, 0, 0, 1'b0);
        cycle(2'b01, 2'b00, 0, 0, 1'b0);
        cycle(2'b10, 2'b00, 0, 0, 1'b0);
        chk("prot_g0", capg, 0);
        chk("prot_set", int'(f1.prot_err), 1);
        cycle(2'b00, 2'b01, 11, 0, 1'b0);
        cycle(2'b10, 2'b00, 0, 0, 1'b0);
        chk("prot_g2", capg, 2);

        // Flush with concurrent traffic.
        cycle(2'b11, 2'b11, 13, 14, 1'b1);
        chk("flush_grant", capg, 0);
        chk("flush_count", int'(f1.free_count), 8);
        chk("flush_ovf_kept", int'(f1.ovf_err), 1);
        req2 = 2'b11;
        cycle(2'b11, 2'b00, 0, 0, 1'b0);
        req2 = 2'b00;
        chk("flush_lo", cap0, 0);
        chk("flush_hi", cap1, 1);
        chk("flush_stride_lo", cap2_0, 0);
        chk("flush_stride_hi", cap2_1, 4);

        // Async reset pulse between edges.
        f1.alloc_req = '0; f1.rel_vld = '0; f1.flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_ovf", int'(f1.ovf_err), 0);
        chk("arst_prot", int'(f1.prot_err), 0);
        chk("arst_count", int'(f1.free_count), 8);
        rst = 1'b0;
        model_reset();
        m_ovf = 1'b0; m_prot = 1'b0;
        #9;

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 9))
                0, 1:    rq = 2'b00;
                2, 3, 4: rq = 2'b01;
                9:       rq = 2'b10;
                default: rq = 2'b11;
            endcase
            cycle(rq, 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
